// File: rtl/instr_fetch_unit.sv
// PC generation and fetch queue feeding decode.
// Registered head output; redirect flushes, halt is sticky.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  output logic [31:0]                    imem_addr,
  input  logic [31:0]                    imem_instr,
  input  logic                           redirect_valid,
  input  logic [31:0]                    redirect_pc,
  input  logic                           halt_req,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [31:0]                    out_instr,
  output logic [31:0]                    out_pc,
  output logic                           halted,
  output logic [$clog2(QUEUE_DEPTH):0]   q_count
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_t;

  state_t         state;
  logic [31:0]    pc;
  logic [31:0]    mem_pc    [QUEUE_DEPTH];
  logic [31:0]    mem_instr [QUEUE_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           pop;
  logic           push;
  logic [PW-1:0]  rd_next;
  logic [CW-1:0]  remain;

  assign imem_addr = pc;
  assign q_count   = count;
  assign halted    = (state == S_HALT);

  // Handshake and next head pointer
  always_comb begin
    pop     = out_valid & out_ready;
    push    = (state == S_RUN) & ~redirect_valid & ~halt_req &
              ((count < CW'(QUEUE_DEPTH)) | pop);
    rd_next = rd_ptr + PW'(pop);
    remain  = count - CW'(pop);
  end

  // Queue storage, written at the tail on every push
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= pc;
      mem_instr[wr_ptr] <= imem_instr;
    end
  end

  // PC, state, pointers and registered head output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      state     <= S_RUN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else if (redirect_valid) begin
      pc        <= {redirect_pc[31:2], 2'b00};
      state     <= S_RUN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (halt_req) state <= S_HALT;
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr    <= rd_next;
      count     <= remain + CW'(push);
      out_valid <= (remain != '0) | push;
      if (remain != '0) begin
        out_pc    <= mem_pc[rd_next];
        out_instr <= mem_instr[rd_next];
      end else if (push) begin
        out_pc    <= pc;
        out_instr <= imem_instr;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed table, wrap/reset
// sequence, and random traffic against a queue model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_instr;
  logic        redirect_valid, halt_req, out_ready;
  logic [31:0] redirect_pc;
  logic        out_valid, halted;
  logic [31:0] out_instr, out_pc;
  logic [2:0]  q_count;
  logic        mode;

  logic        rst2_n;
  logic [31:0] addr2, instr2, oinstr2, opc2;
  logic        ovalid2, halted2;
  logic [2:0]  count2;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_f(logic m, logic [31:0] a);
    if (m) return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    return 32'hA000_0000 | a;
  endfunction

  assign imem_instr = imem_f(mode, imem_addr);
  assign instr2     = imem_f(1'b0, addr2);

  instr_fetch_unit #(.RESET_PC(32'h0), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .halted(halted), .q_count(q_count)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst2_n),
    .imem_addr(addr2), .imem_instr(instr2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .halt_req(1'b0),
    .out_valid(ovalid2), .out_ready(1'b1),
    .out_instr(oinstr2), .out_pc(opc2),
    .halted(halted2), .q_count(count2)
  );

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic        halt;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    int          ecnt;
    logic        eh;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic r, logic rd, logic h,
                              logic [31:0] rp, logic v,
                              logic [31:0] p, int c,
                              logic eh, logic [31:0] a);
    vec_t t;
    t.ready = r; t.redir = rd; t.halt = h; t.rpc = rp;
    t.ev = v; t.epc = p; t.ecnt = c; t.eh = eh; t.eaddr = a;
    return t;
  endfunction

  // Reference model: queue of fetched words plus fetch PC
  logic [31:0] qp[$];
  logic [31:0] qi[$];
  logic [31:0] m_pc, l_pc, l_ins;
  logic        m_halt;

  task automatic model_reset();
    qp.delete(); qi.delete();
    m_pc = 32'h0; m_halt = 1'b0;
    l_pc = 32'h0; l_ins = 32'h0;
  endtask

  task automatic model_step();
    logic pop, push;
    pop = (qp.size() != 0) && out_ready;
    if (redirect_valid) begin
      qp.delete(); qi.delete();
      m_pc   = {redirect_pc[31:2], 2'b00};
      m_halt = 1'b0;
    end else begin
      push = !m_halt && !halt_req && (qp.size() < 4 || pop);
      if (pop) begin
        void'(qp.pop_front());
        void'(qi.pop_front());
      end
      if (push) begin
        qp.push_back(m_pc);
        qi.push_back(imem_f(mode, m_pc));
        m_pc = m_pc + 32'd4;
      end
      if (halt_req) m_halt = 1'b1;
    end
    if (qp.size() != 0) begin
      l_pc  = qp[0];
      l_ins = qi[0];
    end
  endtask

  task automatic model_cmp();
    chk("rnd_valid", 32'(out_valid), 32'(qp.size() != 0));
    chk("rnd_pc",    out_pc, l_pc);
    chk("rnd_instr", out_instr, l_ins);
    chk("rnd_count", 32'(q_count), 32'(qp.size()));
    chk("rnd_halt",  32'(halted), 32'(m_halt));
    chk("rnd_addr",  imem_addr, m_pc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    halt_req = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(q_count), 32'd0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_pc",    out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_halt",  32'(halted), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst2_n = 1'b0;
    mode   = 1'b0;
    tbl[0]  = mk(0,0,0,0,     1,32'h0,  1,0,32'h4);
    tbl[1]  = mk(0,0,0,0,     1,32'h0,  2,0,32'h8);
    tbl[2]  = mk(0,0,0,0,     1,32'h0,  3,0,32'hC);
    tbl[3]  = mk(0,0,0,0,     1,32'h0,  4,0,32'h10);
    tbl[4]  = mk(0,0,0,0,     1,32'h0,  4,0,32'h10);
    tbl[5]  = mk(1,0,0,0,     1,32'h4,  4,0,32'h14);
    tbl[6]  = mk(0,1,0,32'h103,0,32'h4, 0,0,32'h100);
    tbl[7]  = mk(0,0,0,0,     1,32'h100,1,0,32'h104);
    tbl[8]  = mk(0,0,0,0,     1,32'h100,2,0,32'h108);
    tbl[9]  = mk(1,0,1,0,     1,32'h104,1,1,32'h108);
    tbl[10] = mk(1,0,0,0,     0,32'h104,0,1,32'h108);
    tbl[11] = mk(1,0,0,0,     0,32'h104,0,1,32'h108);
    tbl[12] = mk(1,1,0,32'h40,0,32'h104,0,0,32'h40);
    tbl[13] = mk(1,0,0,0,     1,32'h40, 1,0,32'h44);
    tbl[14] = mk(1,0,0,0,     1,32'h44, 1,0,32'h48);
    tbl[15] = mk(1,1,1,32'h200,0,32'h44,0,0,32'h200);
    tbl[16] = mk(1,0,0,0,     1,32'h200,1,0,32'h204);

    do_reset();
    foreach (tbl[i]) begin
      out_ready      = tbl[i].ready;
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      halt_req       = tbl[i].halt;
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("v%0d_pc", i), out_pc, tbl[i].epc);
      chk($sformatf("v%0d_instr", i), out_instr,
          32'hA000_0000 | tbl[i].epc);
      chk($sformatf("v%0d_count", i), 32'(q_count), 32'(tbl[i].ecnt));
      chk($sformatf("v%0d_halt", i), 32'(halted), 32'(tbl[i].eh));
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].eaddr);
    end

    // PC wrap past the top of the address space, then async reset
    rst2_n = 1'b1;
    chk("wrap_addr0", addr2, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    chk("wrap_pc0", opc2, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    chk("wrap_pc1", opc2, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap_pc2", opc2, 32'h0000_0000);
    chk("wrap_ins2", oinstr2, 32'hA000_0000);
    chk("wrap_cnt", 32'(count2), 32'd1);
    #2 rst2_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ovalid2), 32'd0);
    chk("arst_count", 32'(count2), 32'd0);
    chk("arst_addr", addr2, 32'hFFFF_FFF8);
    chk("arst_halt", 32'(halted2), 32'd0);

    // Random traffic against the model
    mode = 1'b1;
    @(posedge clk); #1;
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 39) == 0);
      halt_req       = ($urandom_range(0, 39) == 0);
      redirect_pc    = $urandom;
      @(posedge clk);
      model_step();
      #1;
      model_cmp();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Program-counter and fetch-queue stage directly upstream of the combinational word-addressed instruction memory. Drives the memory address, captures the returned word with its PC into a small FIFO, and presents instructions to decode over a valid/ready handshake. Handles branch/jump redirects (queue flush) and a sticky halt.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
QUEUE_DEPTH, 4, fetch-queue entries; power of two, 2..16.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
imem_addr  output  32  byte address to instruction memory; equals current PC
imem_instr  input  32  instruction word returned combinationally for imem_addr
redirect_valid  input  1  one-cycle pulse: load new PC and flush queue
redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 0)
halt_req  input  1  one-cycle pulse: stop fetching (sticky)
out_valid  output  1  queue head holds a valid instruction
out_ready  input  1  decode accepts head this cycle
out_instr  output  32  instruction at queue head
out_pc  output  32  PC of out_instr
halted  output  1  high in HALT state
q_count  output  $clog2(QUEUE_DEPTH)+1  current queue occupancy

Behaviour:
- Reset (rst_n low, async): pc=RESET_PC, queue empty, q_count=0, out_valid=0, out_instr=0, out_pc=0, state=RUN, halted=0. Reset mid-operation discards all queued entries immediately.
- imem_addr = pc combinationally; pc always word-aligned.
- States: RUN, HALT. RUN->HALT on halt_req (without redirect_valid). HALT->RUN only on redirect_valid. Reset -> RUN.
- pop = out_valid & out_ready. push = (state==RUN) & ~redirect_valid & ~halt_req & (q_count<QUEUE_DEPTH | pop).
- On push: enqueue {pc, imem_instr} at tail; pc <= pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0). No push: pc holds.
- Full with simultaneous pop: push allowed, q_count unchanged. Empty: out_valid=0, out_instr/out_pc hold last values; out_ready ignored.
- Latency: instruction at pc visible on out_* the cycle after push (registered FIFO output path, no bypass). After reset the first instruction appears at cycle 1 (out_pc=RESET_PC).
- redirect_valid: highest priority. Same edge: queue flushed (q_count=0, out_valid=0 next cycle), pc <= {redirect_pc[31:2],2'b00}, state <= RUN, no push, a pop in that cycle is still counted as accepted by decode (decode discards it).
- halt_req and redirect_valid together: redirect wins, state RUN.
- halt_req alone: no push that cycle or after; queue drains normally via pops; pc holds the next unfetched address.
- Queue pointers wrap modulo QUEUE_DEPTH; q_count saturates logically at QUEUE_DEPTH (never exceeds).
- Memory aliasing above 1 KiB is the memory's concern; this block never masks the PC.

Test Plan:
- Reset release, out_ready=1, imem returns 32'hA000_0000|addr -> out_pc 0,4,8,... on consecutive cycles from cycle 1, out_instr matches, q_count ≤1.
- out_ready=0 for 10 cycles -> q_count reaches 4, pc stops at 16, imem_addr=16 held; release ready -> entries pcs 0,4,8,12 emerge in order, then 16.
- Full queue with out_ready=1 for one cycle -> q_count stays 4, pc advances by exactly 4.
- redirect_valid with redirect_pc=32'h0000_0103 while 3 entries queued -> next cycle out_valid=0, q_count=0, imem_addr=32'h100; following cycle out_pc=32'h100.
- halt_req with 2 entries queued, out_ready=1 -> halted=1, two further outputs, then out_valid=0, pc frozen; redirect to 32'h40 -> halted=0, fetch resumes at 32'h40.
- RESET_PC=32'hFFFF_FFF8, ready=1 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; assert rst_n low mid-stream -> out_valid=0 immediately, q_count=0.
